// File: rtl/hex_page_sequencer.sv
// Page sequencer for a multiplexed HEX display: waits for per-page data, snapshots it,
// dwells, then advances. Optional macro HEX_PAGE_SKIP_EN skips pages masked off in PAGE_MASK.
module hex_page_sequencer #(
  parameter int NUM_PAGES     = 12,
  parameter int DWELL_CYCLES  = 50000000,
  parameter int VALID_TIMEOUT = 5000000
) (
  input  logic        CLK_50,
  input  logic        RESET_N,
  input  logic        AUTO,
  input  logic        KEY_NEXT,
  input  logic [15:0] VALID,
  input  logic [15:0] PAGE_MASK,
  output logic [3:0]  SW_SEL,
  output logic        SNAP_LOAD,
  output logic        STALE,
  output logic        PAGE_WRAP
);

  localparam int WAIT_W  = (VALID_TIMEOUT > 1) ? $clog2(VALID_TIMEOUT) : 1;
  localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(VALID_TIMEOUT - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [3:0]         LAST_PAGE  = 4'(NUM_PAGES - 1);

  typedef enum logic {WAIT_VALID, SHOW} state_t;

  state_t             state, state_nx;
  logic [3:0]         sel_nx;
  logic               snap_nx, stale_nx, wrap_nx;
  logic [WAIT_W-1:0]  wait_cnt, wait_nx;
  logic [DWELL_W-1:0] dwell_cnt, dwell_nx;
  logic [4:0]         nxt;
  logic               adv_req;

`ifdef HEX_PAGE_SKIP_EN
  // Returns {found, index}: first enabled page after cur in wrap order.
  function automatic logic [4:0] next_page(input logic [3:0] cur, input logic [15:0] mask);
    logic [4:0] res;
    int idx;
    res = 5'd0;
    for (int k = NUM_PAGES; k >= 1; k--) begin
      idx = (int'(cur) + k) % NUM_PAGES;
      if (mask[idx[3:0]]) res = {1'b1, idx[3:0]};
    end
    return res;
  endfunction
`else
  function automatic logic [4:0] next_page(input logic [3:0] cur, input logic [15:0] mask);
    logic unused_mask;
    unused_mask = ^mask;
    if (cur >= LAST_PAGE) return 5'b1_0000;
    return {1'b1, cur + 4'd1};
  endfunction
`endif

  always_comb begin
    state_nx = state;
    sel_nx   = SW_SEL;
    snap_nx  = 1'b0;
    wrap_nx  = 1'b0;
    stale_nx = STALE;
    wait_nx  = wait_cnt;
    dwell_nx = dwell_cnt;
    nxt      = next_page(SW_SEL, PAGE_MASK);
    adv_req  = KEY_NEXT || (state == SHOW && AUTO && dwell_cnt == DWELL_LAST);

    // A dropped advance (no enabled page) falls through to normal state handling.
    if (adv_req && nxt[4]) begin
      sel_nx   = nxt[3:0];
      wrap_nx  = (nxt[3:0] < SW_SEL);
      state_nx = WAIT_VALID;
      stale_nx = 1'b0;
      wait_nx  = '0;
      dwell_nx = '0;
    end else if (state == WAIT_VALID) begin
      dwell_nx = '0;
      if (VALID[SW_SEL]) begin
        state_nx = SHOW;
        snap_nx  = 1'b1;
        wait_nx  = '0;
      end else if (wait_cnt == WAIT_LAST) begin
        state_nx = SHOW;
        stale_nx = 1'b1;
        wait_nx  = '0;
      end else begin
        wait_nx  = wait_cnt + 1'b1;
      end
    end else begin
      if (!AUTO) dwell_nx = '0;
      else if (dwell_cnt != DWELL_LAST) dwell_nx = dwell_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= WAIT_VALID;
      SW_SEL    <= 4'd0;
      SNAP_LOAD <= 1'b0;
      STALE     <= 1'b0;
      PAGE_WRAP <= 1'b0;
      wait_cnt  <= '0;
      dwell_cnt <= '0;
    end else begin
      state     <= state_nx;
      SW_SEL    <= sel_nx;
      SNAP_LOAD <= snap_nx;
      STALE     <= stale_nx;
      PAGE_WRAP <= wrap_nx;
      wait_cnt  <= wait_nx;
      dwell_cnt <= dwell_nx;
    end
  end

endmodule

// File: tb/tb_hex_page_sequencer.sv
// Randomized bench for hex_page_sequencer against a cycle-level behavioural page model,
// plus directed scenarios for the corner cases (stale, coincident advances, wrap).
module tb_hex_page_sequencer;

  localparam int NP    = 12;
  localparam int DWELL = 8;
  localparam int TMO   = 4;

  logic        CLK_50 = 1'b0;
  logic        RESET_N = 1'b0;
  logic        AUTO = 1'b0;
  logic        KEY_NEXT = 1'b0;
  logic [15:0] VALID = 16'h0;
  logic [15:0] PAGE_MASK = 16'hFFFF;
  logic [3:0]  SW_SEL;
  logic        SNAP_LOAD, STALE, PAGE_WRAP;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: which page, whether shown yet, and elapsed cycle counts.
  int m_page, m_waited, m_shown;
  bit m_show, m_stale, m_snap, m_wrap;

  int snaps, wraps;

  hex_page_sequencer #(.NUM_PAGES(NP), .DWELL_CYCLES(DWELL), .VALID_TIMEOUT(TMO)) dut (
    .CLK_50(CLK_50), .RESET_N(RESET_N), .AUTO(AUTO), .KEY_NEXT(KEY_NEXT),
    .VALID(VALID), .PAGE_MASK(PAGE_MASK), .SW_SEL(SW_SEL),
    .SNAP_LOAD(SNAP_LOAD), .STALE(STALE), .PAGE_WRAP(PAGE_WRAP)
  );

  always #5 CLK_50 = ~CLK_50;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_next(input int p, input logic [15:0] mask);
`ifdef HEX_PAGE_SKIP_EN
    for (int k = 1; k <= NP; k++) if (mask[(p + k) % NP]) return (p + k) % NP;
    return -1;
`else
    return (p + 1) % NP;
`endif
  endfunction

  task automatic model_reset();
    m_page = 0; m_waited = 0; m_shown = 0;
    m_show = 0; m_stale = 0; m_snap = 0; m_wrap = 0;
  endtask

  task automatic model_clock();
    int  np;
    bit  adv;
    m_snap = 0;
    m_wrap = 0;
    adv = KEY_NEXT || (m_show && AUTO && (m_shown + 1 >= DWELL));
    np  = model_next(m_page, PAGE_MASK);
    if (adv && np >= 0) begin
      m_wrap = (np < m_page);
      m_page = np;
      m_show = 0; m_stale = 0; m_waited = 0; m_shown = 0;
    end else if (!m_show) begin
      if (VALID[m_page]) begin
        m_show = 1; m_snap = 1; m_waited = 0; m_shown = 0;
      end else if (m_waited + 1 >= TMO) begin
        m_show = 1; m_stale = 1; m_waited = 0; m_shown = 0;
      end else begin
        m_waited++;
      end
    end else if (!AUTO) begin
      m_shown = 0;
    end else if (m_shown + 1 < DWELL) begin
      m_shown++;
    end
  endtask

  task automatic check_outputs();
    chk("sw_sel", SW_SEL, m_page);
    chk("snap_load", SNAP_LOAD, m_snap);
    chk("stale", STALE, m_stale);
    chk("page_wrap", PAGE_WRAP, m_wrap);
    snaps += SNAP_LOAD;
    wraps += PAGE_WRAP;
  endtask

  task automatic step();
    @(posedge CLK_50);
    if (!RESET_N) model_reset();
    else model_clock();
    #1;
    check_outputs();
  endtask

  // Asynchronous assert away from any edge, hold two cycles, release between edges.
  task automatic do_reset();
    RESET_N = 1'b0;
    #1;
    model_reset();
    check_outputs();
    step();
    step();
    RESET_N = 1'b1;
  endtask

  initial begin
    model_reset();
    snaps = 0; wraps = 0;
    #2;
    check_outputs();
    step();
    RESET_N = 1'b1;

    // Page 0 loads on the first VALID[0] after release.
    VALID = 16'h0001;
    step();
    chk("first_snap", SNAP_LOAD, 1);
    chk("first_sel", SW_SEL, 0);
    VALID = 16'h0;
    step();
    chk("first_snap_once", SNAP_LOAD, 0);

    // Full auto-scan with data always ready.
    do_reset();
    AUTO = 1'b1; VALID = 16'hFFFF;
    snaps = 0; wraps = 0;
    for (int i = 0; i < NP * (DWELL + 1); i++) step();
    chk("scan_snaps", snaps, NP);
    chk("scan_wraps", wraps, 1);
    chk("scan_sel_end", SW_SEL, 0);

    // Stale page 3.
    do_reset();
    AUTO = 1'b0; VALID = 16'h0; KEY_NEXT = 1'b1;
    for (int i = 0; i < 3; i++) step();
    KEY_NEXT = 1'b0; AUTO = 1'b1;
    chk("stale_sel3", SW_SEL, 3);
    for (int i = 0; i < TMO - 1; i++) step();
    chk("stale_early", STALE, 0);
    step();
    chk("stale_set", STALE, 1);
    chk("stale_nosnap", SNAP_LOAD, 0);
    for (int i = 0; i < DWELL - 1; i++) step();
    chk("stale_hold_sel", SW_SEL, 3);
    step();
    chk("stale_adv_sel", SW_SEL, 4);
    chk("stale_clear", STALE, 0);

    // KEY_NEXT coincident with dwell expiry on page 5.
    do_reset();
    AUTO = 1'b0; VALID = 16'hFFFF; KEY_NEXT = 1'b1;
    for (int i = 0; i < 5; i++) step();
    KEY_NEXT = 1'b0; AUTO = 1'b1;
    step();
    for (int i = 0; i < DWELL - 1; i++) step();
    chk("coinc_pre", SW_SEL, 5);
    KEY_NEXT = 1'b1;
    step();
    KEY_NEXT = 1'b0;
    chk("coinc_sel", SW_SEL, 6);
    step();
    chk("coinc_sel_after", SW_SEL, 6);

    // KEY_NEXT and VALID[2] together while waiting on page 2.
    do_reset();
    AUTO = 1'b0; VALID = 16'h0; KEY_NEXT = 1'b1;
    for (int i = 0; i < 2; i++) step();
    VALID = 16'h0004;
    step();
    chk("abort_sel", SW_SEL, 3);
    chk("abort_nosnap", SNAP_LOAD, 0);
    KEY_NEXT = 1'b0; VALID = 16'h0;
    step();
    chk("abort_nosnap2", SNAP_LOAD, 0);

`ifdef HEX_PAGE_SKIP_EN
    do_reset();
    PAGE_MASK = 16'h0011; AUTO = 1'b0; VALID = 16'h0; KEY_NEXT = 1'b1;
    step();
    chk("skip_sel_a", SW_SEL, 4); chk("skip_wrap_a", PAGE_WRAP, 0);
    step();
    chk("skip_sel_b", SW_SEL, 0); chk("skip_wrap_b", PAGE_WRAP, 1);
    step();
    chk("skip_sel_c", SW_SEL, 4); chk("skip_wrap_c", PAGE_WRAP, 0);
    KEY_NEXT = 1'b0;
`endif

    // Randomized traffic including AUTO toggles and mid-run resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      if ($urandom_range(0, 63) == 0) AUTO = ~AUTO;
      KEY_NEXT = ($urandom_range(0, 11) == 0);
      VALID = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
      if ($urandom_range(0, 99) == 0)
        PAGE_MASK = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
